// File: rtl/html_char_source_pkg.sv
// html_defs: shared character constants, FSM encoding and whitespace mapping for html_char_source
package html_defs;

    localparam int CHAR_BITES = 8;

    localparam logic [CHAR_BITES-1:0] CH_NUL = 8'h00;
    localparam logic [CHAR_BITES-1:0] CH_SP  = 8'h20;
    localparam logic [CHAR_BITES-1:0] CH_TAB = 8'h09;
    localparam logic [CHAR_BITES-1:0] CH_NL  = 8'h0A;
    localparam logic [CHAR_BITES-1:0] CH_CR  = 8'h0D;
    localparam logic [CHAR_BITES-1:0] CH_LT  = 8'h3C;
    localparam logic [CHAR_BITES-1:0] CH_GT  = 8'h3E;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [CHAR_BITES-1:0] ws_map(input logic [CHAR_BITES-1:0] b);
        return (b == CH_TAB || b == CH_NL || b == CH_CR) ? CH_SP : b;
    endfunction

endpackage

// File: rtl/html_char_source_char_fifo.sv
// char_fifo: small prefetch FIFO with combinational head and occupancy count
module char_fifo
    import html_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [CHAR_BITES-1:0]      din,
    output logic [CHAR_BITES-1:0]      dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [CHAR_BITES-1:0] mem [DEPTH];
    logic [AW-1:0]         wp;
    logic [AW-1:0]         rp;

    // storage array, written at the tail on every push
    always_ff @(posedge clock) begin
        if (push) mem[wp] <= din;
    end

    // pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clock) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign dout = mem[rp];

endmodule

// File: rtl/html_char_source.sv
// html_char_source: prefetches the HTML document from ROM and serves it one char per next_char
// Optional feature macro HTML_WS_COLLAPSE_EN: folds TAB/LF/CR to space and collapses space runs.
module html_char_source
    import html_defs::*;
#(
    parameter int ADDR_W     = 12,
    parameter int BASE_ADDR  = 0,
    parameter int DOC_LEN    = 4095,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  next_char,
    output logic [CHAR_BITES-1:0] char,
    output logic                  char_valid,
    output logic                  eof,
    output logic [ADDR_W-1:0]     rom_addr,
    output logic                  rom_rd,
    input  logic [CHAR_BITES-1:0] rom_data
);

    localparam int                CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(BASE_ADDR + DOC_LEN);

    state_t                state;
    state_t                state_nx;
    logic                  inflight;
    logic                  end_flag;
    logic                  nul_land;
    logic                  end_now;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [CHAR_BITES-1:0] push_data;
    logic [CHAR_BITES-1:0] head;
    logic [CW-1:0]         count;
    logic [CW-1:0]         cnt_nx;

    // a NUL landing from ROM terminates the document in the same cycle it arrives
    assign nul_land = inflight && rom_data == CH_NUL;
    assign end_now  = end_flag || nul_land || rom_addr == LIMIT;
    assign pop      = enable && next_char && char_valid;
    // credit counts the read in flight so the FIFO can never overflow
    assign issue    = !reset && enable && !end_now &&
                      (CW+1)'(count) + (CW+1)'(inflight) < (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop);
    assign rom_rd   = issue;
    assign cnt_nx   = count + CW'(push) - CW'(pop);

`ifdef HTML_WS_COLLAPSE_EN
    logic prev_ws;

    assign push_data = ws_map(rom_data);
    assign push      = inflight && rom_data != CH_NUL && !(prev_ws && push_data == CH_SP);

    // remembers whether the last enqueued byte was a space
    always_ff @(posedge clock) begin
        if (reset) prev_ws <= 1'b0;
        else if (push) prev_ws <= push_data == CH_SP;
    end
`else
    assign push_data = rom_data;
    assign push      = inflight && rom_data != CH_NUL;
`endif

    char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .dout  (head),
        .count (count)
    );

    // address counter, one-cycle read tracker and sticky end-of-document flag
    always_ff @(posedge clock) begin
        if (reset) begin
            rom_addr <= ADDR_W'(BASE_ADDR);
            inflight <= 1'b0;
            end_flag <= 1'b0;
        end else begin
            inflight <= issue;
            end_flag <= end_now;
            if (issue) rom_addr <= rom_addr + 1'b1;
        end
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= ST_FILL;
        else state <= state_nx;
    end

    // next state from post-update occupancy; DONE only once nothing can arrive any more
    always_comb begin
        state_nx = state == ST_DONE ? ST_DONE :
                   cnt_nx != '0     ? (end_now ? ST_DRAIN : ST_STREAM) :
                                      (end_now ? ST_DONE  : ST_FILL);
    end

    // parser-facing outputs straight from the FIFO head
    always_comb begin
        char_valid = count != '0 && state != ST_DONE;
        char       = char_valid ? head : '0;
        eof        = state == ST_DONE;
    end

endmodule

// File: tb/tb_html_char_source.sv
// tb_html_char_source: randomized and directed checks of html_char_source against a document-level model
module tb_html_char_source;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        next_char = 1'b0;
    logic [7:0]  c0, c1, d0, d1;
    logic        v0, v1, e0, e1, r0, r1;
    logic [11:0] a0, a1;
    logic [7:0]  mem [0:4095];
    logic [7:0]  got_q [$];
    logic [7:0]  exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          first_pop, last_pop, eof_cyc, max_out;
    bit          stall_seen, held_bad;

    always #5 clock = ~clock;

    html_char_source u0 (
        .clock(clock), .reset(reset), .enable(enable), .next_char(next_char),
        .char(c0), .char_valid(v0), .eof(e0), .rom_addr(a0), .rom_rd(r0), .rom_data(d0)
    );

    html_char_source #(.DOC_LEN(3)) u1 (
        .clock(clock), .reset(reset), .enable(enable), .next_char(next_char),
        .char(c1), .char_valid(v1), .eof(e1), .rom_addr(a1), .rom_rd(r1), .rom_data(d1)
    );

    // synchronous ROMs; unrequested cycles return junk that must never be used
    always @(posedge clock) begin
        d0 <= r0 ? mem[a0] : 8'($urandom);
        d1 <= r1 ? mem[a1] : 8'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input string s);
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) mem[i] = s[i];
    endtask

    task automatic load_rand(input int n);
        string alphabet = "ab<>/p \t\n\rxz";
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int i = 0; i < n; i++) mem[i] = alphabet[$urandom_range(alphabet.len() - 1)];
    endtask

    // expected delivered text: bytes up to NUL or the length limit, optionally whitespace-collapsed
    task automatic build(input int lim);
        logic [7:0] b;
        bit prev = 0;
        exp_q = {};
        for (int i = 0; i < lim; i++) begin
            b = mem[i];
            if (b == 8'h00) break;
`ifdef HTML_WS_COLLAPSE_EN
            if (b == 8'h09 || b == 8'h0A || b == 8'h0D) b = 8'h20;
            if (b == 8'h20 && prev) continue;
            prev = b == 8'h20;
`endif
            exp_q.push_back(b);
        end
    endtask

    task automatic cmp_seq(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check(tag, got_q[i], exp_q[i]);
    endtask

    task automatic run(input int sel, input int nc_mode, input int en_mode, input int budget, input bit need_eof);
        logic [7:0] ch, prev_ch;
        logic cv, ev, rd, prev_cv, prev_en;
        int reads, pops;
        got_q = {};
        first_pop = -1; last_pop = -1; eof_cyc = -1; max_out = 0;
        stall_seen = 0; held_bad = 0; reads = 0; pops = 0;
        prev_cv = 0; prev_en = 1; prev_ch = 0;
        reset = 1; enable = 0; next_char = 0;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        for (int c = 0; c < budget; c++) begin
            enable    = en_mode == 0 ? 1'b1 : en_mode == 1 ? !(c >= 5 && c < 10) : ($urandom % 4 != 0);
            next_char = nc_mode == 0 ? 1'b1 : nc_mode == 1 ? (c % 4 == 0) : 1'($urandom % 2);
            @(negedge clock);
            ch = sel ? c1 : c0; cv = sel ? v1 : v0; ev = sel ? e1 : e0; rd = sel ? r1 : r0;
            if (rd) reads++;
            if (rd && !enable) held_bad = 1;
            if (!enable && !prev_en && prev_cv && ch !== prev_ch) held_bad = 1;
            if (!rd && enable && !ev && reads < exp_q.size()) stall_seen = 1;
            if (enable && next_char && cv) begin
                got_q.push_back(ch);
                pops++;
                if (first_pop < 0) first_pop = c;
                last_pop = c;
            end
            if (reads - pops > max_out) max_out = reads - pops;
            prev_ch = ch; prev_cv = cv; prev_en = enable;
            @(posedge clock);
            #1;
            if (ev) begin
                eof_cyc = c;
                break;
            end
        end
        if (need_eof && eof_cyc < 0) check("eof_timeout", 0, 1);
    endtask

    initial begin
        bit ok;
        int sel;
        reset = 1; enable = 1; next_char = 1;
        load("<p>hi</p>");
        @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_valid", v0, 0);
        check("rst_eof", e0, 0);
        check("rst_addr", a0, 0);
        check("rst_rd", r0, 0);
        check("rst_char", c0, 0);
        @(posedge clock);
        #1;

        build(4095);
        run(0, 0, 0, 200, 1);
        cmp_seq("held_seq");
        check("held_len9", got_q.size(), 9);
        check("held_first", first_pop, 2);
        check("held_contig", last_pop - first_pop, 8);
        check("held_eof", eof_cyc, last_pop + 1);
        enable = 1; next_char = 1;
        ok = 1;
        repeat (3) begin
            @(negedge clock);
            if (v0 !== 1'b0 || e0 !== 1'b1 || r0 !== 1'b0 || c0 !== 8'h00) ok = 0;
            @(posedge clock);
            #1;
        end
        check("done_stable", ok, 1);

        run(0, 1, 0, 400, 1);
        cmp_seq("pulse_seq");
        check("pulse_bound", max_out >= 4 && max_out <= 5, 1);
        check("pulse_stall", stall_seen, 1);

        load("abcdef");
        build(3);
        run(1, 0, 0, 200, 1);
        cmp_seq("len3_seq");
        check("len3_addr", a1, 3);
        check("len3_eof", e1, 1);

        load("a \n\t b");
        build(4095);
        run(0, 0, 0, 200, 1);
        cmp_seq("ws_seq");
`ifdef HTML_WS_COLLAPSE_EN
        check("ws_len", got_q.size(), 3);
`else
        check("ws_len", got_q.size(), 6);
`endif

        load("<p>hi</p>");
        build(4095);
        run(0, 0, 0, 6, 0);
        check("mid_pops", got_q.size(), 4);
        check("mid_last", got_q[$], "h");
        reset = 1;
        @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        check("mid_valid", v0, 0);
        check("mid_eof", e0, 0);
        check("mid_addr", a0, 0);
        @(posedge clock);
        #1;
        run(0, 0, 0, 200, 1);
        cmp_seq("restart_seq");
        check("restart_first", first_pop, 2);

        run(0, 0, 1, 200, 1);
        cmp_seq("enlow_seq");
        check("enlow_frozen", held_bad, 0);

        for (int t = 0; t < 20; t++) begin
            sel = $urandom % 3 == 0 ? 1 : 0;
            load_rand($urandom_range(1, 40));
            build(sel ? 3 : 4095);
            run(sel, 2, 2, 2000, 1);
            cmp_seq("rand_seq");
            check("rand_frozen", held_bad, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
